// File: rtl/cpu_types_pkg.sv
// Shared types for the fetch slice: word type, next-PC select codes and
// fetch controller states.
package cpu_types_pkg;

    typedef logic [31:0] word_t;

    // Select codes understood by the external next-PC mux.
    typedef enum logic [1:0] {
        NPC_PLUS4  = 2'd0,
        NPC_JR     = 2'd1,
        NPC_BRANCH = 2'd2,
        NPC_JUMP   = 2'd3
    } npc_sel_t;

    typedef enum logic [1:0] {
        FETCH  = 2'd0,
        HOLD   = 2'd1,
        DRAIN  = 2'd2,
        HALTED = 2'd3
    } fetch_state_t;

    localparam word_t PC_STEP = 32'd4;

    // Execute-stage redirects are older than decode-stage jumps, so they win;
    // a taken branch outranks a register jump.
    function automatic npc_sel_t npc_select(input logic branch_taken,
                                            input logic jump_reg_valid,
                                            input logic jump_valid);
        if (branch_taken)
            return NPC_BRANCH;
        else if (jump_reg_valid)
            return NPC_JR;
        else if (jump_valid)
            return NPC_JUMP;
        else
            return NPC_PLUS4;
    endfunction

endpackage

// File: rtl/pc_fetch_ctrl_if.sv
// Bundle of redirect, next-PC mux, icache and IF/ID signals around the
// fetch controller. master = fetch controller, slave = its surroundings.
interface pc_fetch_ctrl_if;
    import cpu_types_pkg::*;

    // redirect requests and next-PC mux
    logic        branchTaken;
    logic        jumpRegValid;
    logic        jumpValid;
    logic [1:0]  nextPCSelect;
    word_t       nextPC;
    word_t       pc;
    word_t       pcPlus4;

    // icache
    logic        iRequest;
    word_t       iAddr;
    logic        iHit;
    word_t       iData;

    // IF/ID and pipeline control
    logic        stall;
    logic        halt;
    logic        instrValid;
    word_t       instr;
    word_t       instrPC;

    modport master (
        input  branchTaken, jumpRegValid, jumpValid, nextPC,
        input  iHit, iData, stall, halt,
        output nextPCSelect, pc, pcPlus4, iRequest, iAddr,
        output instrValid, instr, instrPC
    );

    modport slave (
        output branchTaken, jumpRegValid, jumpValid, nextPC,
        output iHit, iData, stall, halt,
        input  nextPCSelect, pc, pcPlus4, iRequest, iAddr,
        input  instrValid, instr, instrPC
    );

endinterface

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc} holding register that catches an icache hit
// returning while IF/ID is stalled.
module fetch_skid_buf
    import cpu_types_pkg::*;
(
    input  logic  CLK,
    input  logic  RST,
    input  logic  load,
    input  logic  clear,
    input  word_t load_instr,
    input  word_t load_pc,
    output logic  valid,
    output word_t instr,
    output word_t pc
);

    // Capture on load, drop on clear; clear wins so a discard is never lost.
    always_ff @(posedge CLK or posedge RST) begin
        // NOTE: state registers use non-blocking assignments so every flop
        // samples pre-edge values regardless of statement order.
        if (RST) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (clear) begin
            valid <= 1'b0;
            instr <= '0;
            pc    <= '0;
        end else if (load) begin
            valid <= 1'b1;
            instr <= load_instr;
            pc    <= load_pc;
        end
    end

endmodule

// File: rtl/pc_fetch_ctrl.sv
// IF-stage fetch controller: owns the PC, issues icache reads, steers the
// next-PC mux and delivers instructions to IF/ID via a registered output
// backed by a one-entry skid buffer.
module pc_fetch_ctrl
    import cpu_types_pkg::*;
#(
    parameter word_t RESET_PC = 32'h0000_0000
) (
    input  logic              CLK,
    input  logic              RST,
    pc_fetch_ctrl_if.master   bus
);

    fetch_state_t state_q;
    word_t        pc_q;
    word_t        redirect_target_q;
    logic         instr_valid_q;
    word_t        instr_q;
    word_t        instr_pc_q;

    logic         redirect;
    npc_sel_t     npc_sel;
    logic         skid_load;
    logic         skid_clear;
    logic         skid_valid;
    word_t        skid_instr;
    word_t        skid_pc;

    // Redirect decode and skid control, evaluated every cycle.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no path
        // leaves it unassigned and infers a latch.
        npc_sel    = npc_select(bus.branchTaken, bus.jumpRegValid, bus.jumpValid);
        redirect   = bus.branchTaken | bus.jumpRegValid | bus.jumpValid;
        skid_load  = 1'b0;
        skid_clear = 1'b0;
        if (bus.halt) begin
            skid_clear = 1'b1;
        end else if (state_q == FETCH) begin
            skid_load = !redirect && bus.iHit && bus.stall;
        end else if (state_q == HOLD) begin
            skid_clear = redirect || !bus.stall;
        end
    end

    fetch_skid_buf u_skid (
        .CLK        (CLK),
        .RST        (RST),
        .load       (skid_load),
        .clear      (skid_clear),
        .load_instr (bus.iData),
        .load_pc    (pc_q),
        .valid      (skid_valid),
        .instr      (skid_instr),
        .pc         (skid_pc)
    );

    // Fetch FSM with PC, redirect target and IF/ID output register.
    // pc_q only moves on a hit or outside a request, so iAddr is stable
    // across a pending miss.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q           <= FETCH;
            pc_q              <= RESET_PC;
            redirect_target_q <= '0;
            instr_valid_q     <= 1'b0;
            instr_q           <= '0;
            instr_pc_q        <= '0;
        end else if (bus.halt) begin
            state_q       <= HALTED;
            instr_valid_q <= 1'b0;
        end else begin
            case (state_q)
                FETCH: begin
                    if (redirect) begin
                        instr_valid_q <= 1'b0;
                        if (bus.iHit) begin
                            pc_q <= bus.nextPC;
                        end else begin
                            redirect_target_q <= bus.nextPC;
                            state_q           <= DRAIN;
                        end
                    end else if (bus.iHit) begin
                        pc_q <= bus.nextPC;
                        if (bus.stall) begin
                            state_q <= HOLD;
                        end else begin
                            instr_q       <= bus.iData;
                            instr_pc_q    <= pc_q;
                            instr_valid_q <= 1'b1;
                        end
                    end else if (!bus.stall) begin
                        instr_valid_q <= 1'b0;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        instr_valid_q <= 1'b0;
                        pc_q          <= bus.nextPC;
                        state_q       <= FETCH;
                    end else if (!bus.stall) begin
                        instr_q       <= skid_instr;
                        instr_pc_q    <= skid_pc;
                        instr_valid_q <= skid_valid;
                        state_q       <= FETCH;
                    end
                end
                DRAIN: begin
                    instr_valid_q <= 1'b0;
                    if (bus.iHit) begin
                        pc_q              <= redirect ? bus.nextPC : redirect_target_q;
                        redirect_target_q <= '0;
                        state_q           <= FETCH;
                    end else if (redirect) begin
                        redirect_target_q <= bus.nextPC;
                    end
                end
                HALTED: begin
                    instr_valid_q <= 1'b0;
                end
                default: begin
                    state_q <= FETCH;
                end
            endcase
        end
    end

    assign bus.nextPCSelect = npc_sel;
    assign bus.pc           = pc_q;
    assign bus.pcPlus4      = pc_q + PC_STEP;
    assign bus.iAddr        = pc_q;
    assign bus.iRequest     = !RST && ((state_q == FETCH) || (state_q == DRAIN));
    assign bus.instrValid   = instr_valid_q;
    assign bus.instr        = instr_q;
    assign bus.instrPC      = instr_pc_q;

endmodule
